// File: rtl/fp16_lane_packer_if.sv
// Handshake bundle between the FP16 converter side, the packer and the
// vector write-back consumer.
interface fp16_lane_packer_if #(
    parameter int LANES = 4
) ();
    logic                      in_valid;
    logic [15:0]               in_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [16*LANES-1:0]       out_data;
    logic [$clog2(LANES):0]    out_lanes;

    modport master (
        output in_valid,
        output in_data,
        output flush,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_lanes
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  flush,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_lanes
    );
endinterface

// File: rtl/fp16_lane_packer.sv
// Packs serial FP16 converter results into LANES-wide words and queues
// them in a small FIFO towards vector register write-back.
module fp16_lane_packer #(
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fp16_lane_packer_if.slave       bus,
    output logic [15:0]             sat_cnt,
    output logic [15:0]             drop_cnt
);
    localparam int IW = $clog2(LANES);
    localparam int LW = IW + 1;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int WW = 16 * LANES;
    localparam int EW = LW + WW;

    localparam logic [IW-1:0] IDX_LAST = IW'(LANES - 1);
    localparam logic [LW-1:0] LANES_ALL = LW'(LANES);

    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] asm_q, asm_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          out_valid_q, out_valid_d;
    logic [WW-1:0] out_data_q, out_data_d;
    logic [LW-1:0] out_lanes_q, out_lanes_d;
    logic [15:0]   sat_cnt_q, sat_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic [WW-1:0] merged;
    logic [LW-1:0] push_lanes;
    logic [EW-1:0] head;
    logic          complete;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;
    logic          drop;

    always_comb begin
        merged = asm_q;
        for (int k = 0; k < LANES; k++) begin
            if (bus.in_valid && idx_q == IW'(k)) begin
                merged[16*k +: 16] = bus.in_data;
            end
        end
    end

    // A flush on an empty assembly only pushes if a sample arrives with it.
    always_comb begin
        complete = bus.in_valid && (idx_q == IDX_LAST);
        push = complete
            || (bus.flush && (idx_q != '0 || bus.in_valid));
        if (complete) begin
            push_lanes = LANES_ALL;
        end else begin
            push_lanes = {1'b0, idx_q}
                + {{IW{1'b0}}, bus.in_valid};
        end
    end

    always_comb begin
        full = (wptr_q[AW] != rptr_q[AW])
            && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop = out_valid_q && bus.out_ready;
        accept = push && (!full || pop);
        drop = push && full && !pop;
    end

    always_comb begin
        idx_d = idx_q;
        asm_d = merged;
        if (push) begin
            idx_d = '0;
            asm_d = '0;
        end else if (bus.in_valid) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Output regs load the next-cycle head so they stay registered.
    always_comb begin
        mem_d = mem_q;
        if (accept) begin
            mem_d[wptr_q[AW-1:0]] = {push_lanes, merged};
        end
        wptr_d = wptr_q + PW'(accept);
        rptr_d = rptr_q + PW'(pop);
        head = mem_d[rptr_d[AW-1:0]];
        out_valid_d = (wptr_d != rptr_d);
        out_data_d = '0;
        out_lanes_d = '0;
        if (out_valid_d) begin
            out_data_d = head[WW-1:0];
            out_lanes_d = head[EW-1:WW];
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.in_valid && bus.in_data == 16'hFFFF
            && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            asm_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_lanes_q <= '0;
            sat_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
            mem_q <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_lanes_q <= out_lanes_d;
            sat_cnt_q <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data = out_data_q;
    assign bus.out_lanes = out_lanes_q;
    assign sat_cnt = sat_cnt_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_fp16_lane_packer.sv
// Bench for fp16_lane_packer: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_fp16_lane_packer;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int WW = 16 * LANES;
    localparam int LW = $clog2(LANES) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] sat_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    fp16_lane_packer_if #(.LANES(LANES)) bus ();

    fp16_lane_packer #(
        .LANES(LANES),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sat_cnt(sat_cnt),
        .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [LW-1:0] lanes;
        logic [WW-1:0] data;
    } word_t;

    typedef struct {
        logic          v;
        logic [15:0]   d;
        logic          f;
        logic          ev;
        logic [WW-1:0] ed;
        logic [LW-1:0] el;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;

    word_t mq[$];
    logic [15:0] part[$];
    int unsigned m_sat;
    int unsigned m_drop;

    vec_t tbl[16];

    task automatic chk(string name, logic [63:0] act,
                       logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        part.delete();
        m_sat = 0;
        m_drop = 0;
    endtask

    task automatic model_step(logic v, logic [15:0] d,
                              logic f, logic r);
        bit pop;
        word_t w;
        pop = (mq.size() > 0) && r;
        if (v) begin
            part.push_back(d);
            if (d == 16'hFFFF && m_sat < 65535) m_sat++;
        end
        if (pop) void'(mq.pop_front());
        if (part.size() == LANES || (f && part.size() > 0)) begin
            w.data = '0;
            w.lanes = LW'(part.size());
            foreach (part[i]) w.data[16*i +: 16] = part[i];
            part.delete();
            if (mq.size() < DEPTH) mq.push_back(w);
            else if (m_drop < 65535) m_drop++;
        end
    endtask

    task automatic check_model();
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", bus.out_data, mq[0].data);
            chk("out_lanes", 64'(bus.out_lanes), 64'(mq[0].lanes));
        end
        chk("sat_cnt", 64'(sat_cnt), 64'(m_sat[15:0]));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop[15:0]));
    endtask

    task automatic step(logic v, logic [15:0] d, logic f, logic r);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data = d;
        bus.flush = f;
        bus.out_ready = r;
        @(posedge clk);
        model_step(v, d, f, r);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [WW-1:0] ew;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        tbl[0]  = '{1, 16'h3C00, 0, 0, 64'h0, 3'd0};
        tbl[1]  = '{1, 16'h4000, 0, 0, 64'h0, 3'd0};
        tbl[2]  = '{1, 16'h4200, 0, 0, 64'h0, 3'd0};
        tbl[3]  = '{1, 16'h4400, 0, 1,
                    64'h4400_4200_4000_3C00, 3'd4};
        tbl[4]  = '{1, 16'h3C00, 0, 0, 64'h0, 3'd0};
        tbl[5]  = '{1, 16'h4000, 0, 0, 64'h0, 3'd0};
        tbl[6]  = '{0, 16'h0000, 1, 1,
                    64'h0000_0000_4000_3C00, 3'd2};
        tbl[7]  = '{1, 16'h3C00, 0, 0, 64'h0, 3'd0};
        tbl[8]  = '{1, 16'h4000, 0, 0, 64'h0, 3'd0};
        tbl[9]  = '{1, 16'h4200, 1, 1,
                    64'h0000_4200_4000_3C00, 3'd3};
        tbl[10] = '{1, 16'hFFFF, 0, 0, 64'h0, 3'd0};
        tbl[11] = '{1, 16'h0000, 0, 0, 64'h0, 3'd0};
        tbl[12] = '{1, 16'hFFFF, 0, 0, 64'h0, 3'd0};
        tbl[13] = '{1, 16'h7BFF, 0, 1,
                    64'h7BFF_FFFF_0000_FFFF, 3'd4};
        tbl[14] = '{0, 16'h0000, 1, 0, 64'h0, 3'd0};
        tbl[15] = '{1, 16'h1234, 1, 1,
                    64'h0000_0000_0000_1234, 3'd1};

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", bus.out_data, 64'd0);
        chk("rst_lanes", 64'(bus.out_lanes), 64'd0);
        chk("rst_sat", 64'(sat_cnt), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].f, 1'b1);
            chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_data", bus.out_data, tbl[i].ed);
                chk("tbl_lanes", 64'(bus.out_lanes), 64'(tbl[i].el));
            end
        end
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("tbl_sat", 64'(sat_cnt), 64'd2);

        // Overflow: five words with the consumer stalled.
        for (int i = 0; i < 5 * LANES; i++) begin
            step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
        end
        chk("ovf_drop", 64'(drop_cnt), 64'd1);
        for (int j = 0; j < DEPTH; j++) begin
            for (int k = 0; k < LANES; k++) begin
                ew[16*k +: 16] = 16'(16'h1000 + 4 * j + k);
            end
            chk("drain_word", bus.out_data, ew);
            step(1'b0, 16'h0, 1'b0, 1'b1);
        end
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        // Full FIFO with a pop and a completing sample together.
        for (int i = 0; i < 5 * LANES; i++) begin
            step(1'b1, 16'(16'h2000 + i), 1'b0,
                 (i == 5 * LANES - 1));
        end
        chk("full_pop_drop", 64'(drop_cnt), 64'd1);
        chk("full_pop_head", bus.out_data,
            64'h2007_2006_2005_2004);
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b1);
        end

        // Asynchronous reset mid-word with a partly filled FIFO.
        for (int i = 0; i < 3 * LANES + 2; i++) begin
            step(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_data", bus.out_data, 64'd0);
        chk("arst_lanes", 64'(bus.out_lanes), 64'd0);
        chk("arst_sat", 64'(sat_cnt), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= LANES; i++) begin
            step(1'b1, 16'(16'h5000 + i), 1'b0, 1'b1);
        end
        chk("post_rst_data", bus.out_data, 64'h5004_5003_5002_5001);
        chk("post_rst_lanes", 64'(bus.out_lanes), 64'd4);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic f;
            logic r;
            logic [15:0] d;
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) d = 16'hFFFF;
            else d = 16'($urandom);
            if ((i / 200) % 2 == 0) r = ($urandom_range(0, 3) != 0);
            else r = ($urandom_range(0, 3) == 0);
            step(v, d, f, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
